// File: rtl/and_reduce.sv
// and_reduce: bitwise two-operand logic unit with a pairwise mode and a
// frame-accumulate mode, behind a valid/ready handshake on both sides.
//
// Ports:
//   CLK      - clock, all state changes on the rising edge
//   RST      - synchronous active-high reset
//   A, B     - W-bit operands
//   OP       - [1:0] AND/OR/XOR/pass-A, [2] inverts the final result
//   MODE     - 0 pairwise (one result per beat), 1 accumulate a frame
//   IN_VALID - input beat valid
//   IN_LAST  - final beat of a frame (MODE=1 only)
//   IN_READY - block can accept a beat this cycle
//   F        - result
//   F_VALID  - result valid
//   F_READY  - downstream accepts the result
//   CNT      - number of beats folded into the emitted result
//   ERR      - emitted frame was cut short at MAXLEN beats
module and_reduce #(
   parameter int unsigned W      = 8,
   parameter int unsigned MAXLEN = 16
) (
   input  logic                           CLK,
   input  logic                           RST,
   input  logic [W-1:0]                   A,
   input  logic [W-1:0]                   B,
   input  logic [2:0]                     OP,
   input  logic                           MODE,
   input  logic                           IN_VALID,
   input  logic                           IN_LAST,
   output logic                           IN_READY,
   output logic [W-1:0]                   F,
   output logic                           F_VALID,
   input  logic                           F_READY,
   output logic [$clog2(MAXLEN+1)-1:0]    CNT,
   output logic                           ERR
);

   localparam int unsigned CntW = $clog2(MAXLEN + 1);
   localparam logic [CntW-1:0] MaxCnt = CntW'(MAXLEN);

   typedef enum logic [1:0] {StIdle, StAccum, StOut} state_e;

   state_e            state;
   logic [W-1:0]      acc;
   logic [CntW-1:0]   beats;
   logic [2:0]        op_r;

   logic              accept;
   logic              consume;
   logic [W-1:0]      base_ab;
   logic [W-1:0]      base_ab_r;
   logic [W-1:0]      acc_next;
   logic [CntW-1:0]   beats_next;

   function automatic logic [W-1:0] base_f(input logic [1:0] op,
                                           input logic [W-1:0] x,
                                           input logic [W-1:0] y);
      logic [W-1:0] r;
      unique case (op)
         2'b00:   r = x & y;
         2'b01:   r = x | y;
         2'b10:   r = x ^ y;
         default: r = x;
      endcase
      return r;
   endfunction

   assign IN_READY = !F_VALID || F_READY;

   always_comb begin
      accept     = IN_VALID && IN_READY;
      consume    = F_VALID && F_READY;
      base_ab    = base_f(OP[1:0], A, B);
      // Mid-frame beats use the opcode latched at the start of the frame.
      base_ab_r  = base_f(op_r[1:0], A, B);
      acc_next   = base_f(op_r[1:0], acc, base_ab_r);
      beats_next = beats + CntW'(1);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= StIdle;
         F       <= '0;
         F_VALID <= 1'b0;
         CNT     <= '0;
         ERR     <= 1'b0;
         acc     <= '0;
         beats   <= '0;
         op_r    <= '0;
      end else begin
         // A consumed result drops valid unless a new one is emitted below.
         if (consume) begin
            F_VALID <= 1'b0;
         end
         unique case (state)
            StIdle, StOut: begin
               if (accept) begin
                  if (!MODE) begin
                     F       <= base_ab ^ {W{OP[2]}};
                     CNT     <= CntW'(1);
                     ERR     <= 1'b0;
                     F_VALID <= 1'b1;
                     state   <= StOut;
                  end else begin
                     op_r  <= OP;
                     acc   <= base_ab;
                     beats <= CntW'(1);
                     if (IN_LAST) begin
                        F       <= base_ab ^ {W{OP[2]}};
                        CNT     <= CntW'(1);
                        ERR     <= 1'b0;
                        F_VALID <= 1'b1;
                        state   <= StOut;
                     end else begin
                        state <= StAccum;
                     end
                  end
               end else if (consume) begin
                  state <= StIdle;
               end
            end
            StAccum: begin
               if (accept) begin
                  acc   <= acc_next;
                  beats <= beats_next;
                  // Hitting MAXLEN without LAST closes the frame as truncated.
                  if (IN_LAST || (beats_next == MaxCnt)) begin
                     F       <= acc_next ^ {W{op_r[2]}};
                     CNT     <= beats_next;
                     ERR     <= !IN_LAST;
                     F_VALID <= 1'b1;
                     state   <= StOut;
                  end
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_and_reduce.sv
// Testbench for and_reduce: directed scenarios followed by random traffic,
// every cycle compared against a frame-level reference model.
module tb_and_reduce;

   localparam int unsigned W      = 8;
   localparam int unsigned MAXLEN = 4;
   localparam int unsigned CntW   = $clog2(MAXLEN + 1);

   logic             CLK = 1'b0;
   logic             RST;
   logic [W-1:0]     A;
   logic [W-1:0]     B;
   logic [2:0]       OP;
   logic             MODE;
   logic             IN_VALID;
   logic             IN_LAST;
   logic             IN_READY;
   logic [W-1:0]     F;
   logic             F_VALID;
   logic             F_READY;
   logic [CntW-1:0]  CNT;
   logic             ERR;

   int total = 0;
   int bad   = 0;

   // Reference model: the pending result slot and the beats of the open frame.
   logic          m_valid;
   logic [W-1:0]  m_f;
   int            m_cnt;
   logic          m_err;
   logic          in_frame;
   logic [2:0]    f_op;
   logic [W-1:0]  qa[$];
   logic [W-1:0]  qb[$];

   always #5 CLK = ~CLK;

   and_reduce #(
      .W      (W),
      .MAXLEN (MAXLEN)
   ) dut (
      .CLK      (CLK),
      .RST      (RST),
      .A        (A),
      .B        (B),
      .OP       (OP),
      .MODE     (MODE),
      .IN_VALID (IN_VALID),
      .IN_LAST  (IN_LAST),
      .IN_READY (IN_READY),
      .F        (F),
      .F_VALID  (F_VALID),
      .F_READY  (F_READY),
      .CNT      (CNT),
      .ERR      (ERR)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Fold of every operand in the frame: the whole frame reduces with one
   // operator, while pass-A keeps the very first A.
   function automatic logic [W-1:0] reduce_frame();
      logic [W-1:0] r;
      case (f_op[1:0])
         2'b00: begin
            r = '1;
            for (int i = 0; i < qa.size(); i++) r = r & qa[i] & qb[i];
         end
         2'b01: begin
            r = '0;
            for (int i = 0; i < qa.size(); i++) r = r | qa[i] | qb[i];
         end
         2'b10: begin
            r = '0;
            for (int i = 0; i < qa.size(); i++) r = r ^ qa[i] ^ qb[i];
         end
         default: r = qa[0];
      endcase
      return r ^ {W{f_op[2]}};
   endfunction

   task automatic model_reset();
      m_valid  = 1'b0;
      m_f      = '0;
      m_cnt    = 0;
      m_err    = 1'b0;
      in_frame = 1'b0;
      f_op     = '0;
      qa.delete();
      qb.delete();
   endtask

   task automatic close_frame(input logic err);
      m_valid  = 1'b1;
      m_f      = reduce_frame();
      m_cnt    = qa.size();
      m_err    = err;
      in_frame = 1'b0;
      qa.delete();
      qb.delete();
   endtask

   // Advance the model by one clock edge using the inputs currently applied.
   task automatic model_step();
      logic accept;
      if (RST) begin
         model_reset();
         return;
      end
      accept = IN_VALID && (!m_valid || F_READY);
      if (m_valid && F_READY) m_valid = 1'b0;
      if (accept) begin
         if (!in_frame && !MODE) begin
            f_op = OP;
            qa.push_back(A);
            qb.push_back(B);
            close_frame(1'b0);
         end else begin
            if (!in_frame) begin
               in_frame = 1'b1;
               f_op     = OP;
            end
            qa.push_back(A);
            qb.push_back(B);
            if (IN_LAST) close_frame(1'b0);
            else if (qa.size() == MAXLEN) close_frame(1'b1);
         end
      end
   endtask

   task automatic set_in(input logic v, input logic last, input logic mode,
                         input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic fr);
      IN_VALID = v;
      IN_LAST  = last;
      MODE     = mode;
      OP       = op;
      A        = a;
      B        = b;
      F_READY  = fr;
   endtask

   // One cycle: compare against the model on the falling edge, then let the
   // rising edge happen and return 1 time unit after it.
   task automatic tick();
      @(negedge CLK);
      chk("in_ready", IN_READY, !m_valid || F_READY);
      chk("f_valid", F_VALID, m_valid);
      chk("f", F, m_f);
      chk("cnt", CNT, m_cnt);
      chk("err", ERR, m_err);
      model_step();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      RST = 1'b1;
      set_in(1'b0, 1'b0, 1'b0, 3'b000, '0, '0, 1'b1);
      model_reset();
      @(posedge CLK);
      #1;
      tick();
      chk("rst_f_valid", F_VALID, 1'b0);
      chk("rst_f", F, 8'h00);
      chk("rst_cnt", CNT, 0);
      RST = 1'b0;
      #1;
      chk("rst_in_ready", IN_READY, 1'b1);

      // Pairwise AND, latency 1, valid for exactly one cycle.
      set_in(1'b1, 1'b0, 1'b0, 3'b000, 8'hF0, 8'h3C, 1'b1);
      tick();
      set_in(1'b0, 1'b0, 1'b0, 3'b000, 8'h00, 8'h00, 1'b1);
      chk("pair_f", F, 8'h30);
      chk("pair_cnt", CNT, 1);
      chk("pair_valid", F_VALID, 1'b1);
      tick();
      chk("pair_valid_drop", F_VALID, 1'b0);

      // NAND frame of three beats.
      set_in(1'b1, 1'b0, 1'b1, 3'b100, 8'hFF, 8'hFE, 1'b1);
      tick();
      set_in(1'b1, 1'b0, 1'b1, 3'b100, 8'hF7, 8'hFF, 1'b1);
      tick();
      set_in(1'b1, 1'b1, 1'b1, 3'b100, 8'h7F, 8'hFF, 1'b1);
      tick();
      chk("nand_f", F, 8'h89);
      chk("nand_cnt", CNT, 3);
      chk("nand_err", ERR, 1'b0);

      // XOR frame truncated at MAXLEN; the fifth beat opens a new frame.
      for (int i = 0; i < 4; i++) begin
         set_in(1'b1, 1'b0, 1'b1, 3'b010, 8'h01, 8'h00, 1'b1);
         tick();
      end
      chk("trunc_f", F, 8'h00);
      chk("trunc_cnt", CNT, 4);
      chk("trunc_err", ERR, 1'b1);
      chk("trunc_valid", F_VALID, 1'b1);
      tick();
      set_in(1'b1, 1'b1, 1'b1, 3'b010, 8'h01, 8'h00, 1'b1);
      tick();
      chk("newframe_cnt", CNT, 2);
      chk("newframe_err", ERR, 1'b0);

      // Backpressure: result held, next beat waits, then consume+accept.
      set_in(1'b1, 1'b0, 1'b0, 3'b000, 8'hFF, 8'h0F, 1'b1);
      tick();
      set_in(1'b1, 1'b0, 1'b0, 3'b001, 8'h11, 8'h22, 1'b0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("hold_ready", IN_READY, 1'b0);
         chk("hold_f", F, 8'h0F);
      end
      F_READY = 1'b1;
      #1;
      chk("release_ready", IN_READY, 1'b1);
      tick();
      set_in(1'b0, 1'b0, 1'b0, 3'b000, 8'h00, 8'h00, 1'b1);
      chk("release_f", F, 8'h33);
      chk("release_valid", F_VALID, 1'b1);
      tick();

      // Reset mid-frame discards the partial frame.
      set_in(1'b1, 1'b0, 1'b1, 3'b000, 8'hAA, 8'hFF, 1'b1);
      tick();
      tick();
      RST = 1'b1;
      tick();
      chk("midrst_valid", F_VALID, 1'b0);
      chk("midrst_f", F, 8'h00);
      chk("midrst_cnt", CNT, 0);
      chk("midrst_err", ERR, 1'b0);
      RST = 1'b0;
      set_in(1'b1, 1'b1, 1'b1, 3'b001, 8'h0A, 8'h50, 1'b1);
      tick();
      chk("postrst_f", F, 8'h5A);
      chk("postrst_cnt", CNT, 1);

      // OP and MODE changes mid-frame are ignored.
      set_in(1'b1, 1'b0, 1'b1, 3'b000, 8'hF0, 8'hFF, 1'b1);
      tick();
      set_in(1'b1, 1'b0, 1'b0, 3'b001, 8'h3C, 8'hFF, 1'b1);
      tick();
      set_in(1'b1, 1'b1, 1'b1, 3'b001, 8'hFF, 8'hFF, 1'b1);
      tick();
      chk("opchg_f", F, 8'h30);
      chk("opchg_cnt", CNT, 3);

      // Random traffic against the model.
      for (int i = 0; i < 600; i++) begin
         RST = ($urandom_range(0, 59) == 0);
         set_in(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                8'($urandom), 8'($urandom), 1'($urandom_range(0, 2) != 0));
         tick();
      end
      RST = 1'b0;
      set_in(1'b0, 1'b0, 1'b0, 3'b000, '0, '0, 1'b1);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
